// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch mode controller: state encoding and BCD time widths.
// Optional lap feature is selected with STOPWATCH_LAP_EN.
package stopwatch_pkg;

    localparam int TIME_W  = 24;
    localparam int DIGIT_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;
    localparam state_t ST_LAP   = 2'd3;

    // States in which the counter advances and a long Clear press is armed.
    function automatic logic is_counting(input state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_event.sv
// Per-key edge detector with an optional long-press hold counter.
// Used by stopwatch_ctrl (lap key instance exists only with STOPWATCH_LAP_EN).
module key_event #(
    parameter int LONG_CYC = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    input  logic i_long_en,
    input  logic i_long_clr,
    output logic o_press,
    output logic o_long
);

    localparam int CNT_W = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LONG_CYC - 1);

    logic             r_armed;
    logic             r_prev;
    logic [CNT_W-1:0] r_hold;

    // r_armed masks the first post-reset cycle so a key held through reset
    // only loads r_prev and never counts as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
            r_prev  <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_armed <= 1'b1;
            r_prev  <= i_key;
            if (!i_key || !i_long_en || i_long_clr) begin
                r_hold <= '0;
            end else if (r_hold != CNT_MAX) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end

    assign o_press = i_key & ~r_prev & r_armed;
    assign o_long  = i_key & i_long_en & (r_hold == CNT_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: key events -> counter enable/clear, display hold for lap.
// Define STOPWATCH_LAP_EN to build the LAP state, lap key handling and display freeze.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ      = 10000000,
    parameter int LONG_PRESS_MS = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_start,
    input  logic              key_clear,
    input  logic              key_lap,
    input  logic [TIME_W-1:0] time_in,
    output logic              cnt_en,
    output logic              cnt_clr,
    output logic [TIME_W-1:0] disp_time,
    output logic              disp_frozen,
    output logic [1:0]        state_o
);

    localparam int LONG_CYC = CLK_FREQ / 1000 * LONG_PRESS_MS;

    state_t            r_state;
    logic              r_cnt_en;
    logic              r_cnt_clr;
    logic [TIME_W-1:0] r_disp;

    state_t w_next;
    logic   w_do_clr;
    logic   w_state_chg;
    logic   w_long_en;
    logic   w_start_press;
    logic   w_clr_press;
    logic   w_clr_long;
    logic   w_lap_press;
    logic   w_start_long_unused;
    logic   w_unused;

    assign w_long_en   = is_counting(r_state);
    assign w_state_chg = (w_next != r_state);

    key_event #(.LONG_CYC(LONG_CYC)) u_key_start (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_key      (key_start),
        .i_long_en  (1'b0),
        .i_long_clr (1'b0),
        .o_press    (w_start_press),
        .o_long     (w_start_long_unused)
    );

    key_event #(.LONG_CYC(LONG_CYC)) u_key_clear (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_key      (key_clear),
        .i_long_en  (w_long_en),
        .i_long_clr (w_state_chg),
        .o_press    (w_clr_press),
        .o_long     (w_clr_long)
    );

`ifdef STOPWATCH_LAP_EN
    logic w_lap_long_unused;

    key_event #(.LONG_CYC(LONG_CYC)) u_key_lap (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_key      (key_lap),
        .i_long_en  (1'b0),
        .i_long_clr (1'b0),
        .o_press    (w_lap_press),
        .o_long     (w_lap_long_unused)
    );
    assign w_unused = w_start_long_unused ^ w_lap_long_unused;
`else
    assign w_lap_press = 1'b0;
    assign w_unused    = w_start_long_unused ^ key_lap;
`endif

    // Each state tests only the events it reacts to, highest priority first;
    // a losing event is simply dropped.
    always_comb begin
        w_next   = r_state;
        w_do_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_clr_press) w_do_clr = 1'b1;
                else if (w_start_press) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_clr_long) begin
                    w_next   = ST_IDLE;
                    w_do_clr = 1'b1;
                end else if (w_start_press) w_next = ST_PAUSE;
                else if (w_lap_press) w_next = ST_LAP;
            end
            ST_PAUSE: begin
                if (w_clr_press) begin
                    w_next   = ST_IDLE;
                    w_do_clr = 1'b1;
                end else if (w_start_press) w_next = ST_RUN;
            end
            ST_LAP: begin
                if (w_clr_long) begin
                    w_next   = ST_IDLE;
                    w_do_clr = 1'b1;
                end else if (w_start_press) w_next = ST_PAUSE;
                else if (w_lap_press) w_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt_en  <= 1'b0;
            r_cnt_clr <= 1'b0;
            r_disp    <= '0;
        end else begin
            r_state   <= w_next;
            r_cnt_en  <= is_counting(w_next);
            r_cnt_clr <= w_do_clr;
`ifdef STOPWATCH_LAP_EN
            // The lap-press cycle still loads, so the frozen value is time_in of that cycle.
            if (r_state != ST_LAP) r_disp <= time_in;
`else
            r_disp    <= time_in;
`endif
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic r_frozen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_frozen <= 1'b0;
        else        r_frozen <= (w_next == ST_LAP);
    end
    assign disp_frozen = r_frozen;
`else
    assign disp_frozen = 1'b0;
`endif

    assign cnt_en    = r_cnt_en;
    assign cnt_clr   = r_cnt_clr;
    assign disp_time = r_disp;
    assign state_o   = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with CLK_FREQ=1000, LONG_PRESS_MS=5 (long press = 5 cycles).
// Lap scenarios adapt to STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int W = 29;

    typedef struct packed {
        logic          s;
        logic          c;
        logic          l;
        logic [23:0]   t;
        logic [W-1:0]  exp;
    } step_t;

    logic        clk;
    logic        rst_n;
    logic        key_start;
    logic        key_clear;
    logic        key_lap;
    logic [23:0] time_in;
    logic        cnt_en;
    logic        cnt_clr;
    logic [23:0] disp_time;
    logic        disp_frozen;
    logic [1:0]  state_o;
    logic [W-1:0] w_obs;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got;
    logic [W-1:0] want;
    int checks;
    int failures;

    stopwatch_ctrl #(
        .CLK_FREQ      (1000),
        .LONG_PRESS_MS (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_start   (key_start),
        .key_clear   (key_clear),
        .key_lap     (key_lap),
        .time_in     (time_in),
        .cnt_en      (cnt_en),
        .cnt_clr     (cnt_clr),
        .disp_time   (disp_time),
        .disp_frozen (disp_frozen),
        .state_o     (state_o)
    );

    // Observed vector: {state, cnt_en, cnt_clr, disp_frozen, disp_time}
    assign w_obs = {state_o, cnt_en, cnt_clr, disp_frozen, disp_time};

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver ----------------
    // Called at a negedge; applies keys for one full cycle and returns at the next negedge.
    task automatic tick(input logic s, input logic c, input logic l, input logic [23:0] t);
        key_start = s;
        key_clear = c;
        key_lap   = l;
        time_in   = t;
        @(negedge clk);
    endtask

    function automatic step_t mk(input logic s, input logic c, input logic l, input logic [23:0] t,
                                 input logic [1:0] st, input logic en, input logic clr,
                                 input logic fz, input logic [23:0] d);
        step_t r;
        r.s   = s;
        r.c   = c;
        r.l   = l;
        r.t   = t;
        r.exp = {st, en, clr, fz, d};
        return r;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        step_t seq[$];
        rst_n = 1'b0;
        key_start = 1'b0;
        key_clear = 1'b0;
        key_lap   = 1'b0;
        time_in   = 24'h555555;
        @(negedge clk);
        @(negedge clk);
        exp_q.push_back('0);
        got = w_obs; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset_values got=%h want=%h", got, want);
        end
        rst_n = 1'b1;
        seq.push_back(mk(0, 0, 0, 24'h000001, ST_IDLE, 0, 0, 0, 24'h000001));
        seq.push_back(mk(0, 0, 0, 24'h000002, ST_IDLE, 0, 0, 0, 24'h000002));
        foreach (seq[i]) begin
            exp_q.push_back(seq[i].exp);
            tick(seq[i].s, seq[i].c, seq[i].l, seq[i].t);
            got = w_obs; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_idle step%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_start();
        step_t seq[$];
        seq.push_back(mk(1, 0, 0, 24'h000010, ST_RUN, 1, 0, 0, 24'h000010));
        seq.push_back(mk(1, 0, 0, 24'h000011, ST_RUN, 1, 0, 0, 24'h000011));
        seq.push_back(mk(0, 0, 0, 24'h000012, ST_RUN, 1, 0, 0, 24'h000012));
        foreach (seq[i]) begin
            exp_q.push_back(seq[i].exp);
            tick(seq[i].s, seq[i].c, seq[i].l, seq[i].t);
            got = w_obs; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL start step%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_lap();
        step_t seq[$];
`ifdef STOPWATCH_LAP_EN
        seq.push_back(mk(0, 0, 1, 24'h000123, ST_LAP, 1, 0, 1, 24'h000123));
        seq.push_back(mk(0, 0, 1, 24'h000124, ST_LAP, 1, 0, 1, 24'h000123));
        seq.push_back(mk(0, 0, 0, 24'h000130, ST_LAP, 1, 0, 1, 24'h000123));
        seq.push_back(mk(0, 0, 1, 24'h000131, ST_RUN, 1, 0, 0, 24'h000123));
        seq.push_back(mk(0, 0, 0, 24'h000132, ST_RUN, 1, 0, 0, 24'h000132));
        seq.push_back(mk(0, 0, 0, 24'h000133, ST_RUN, 1, 0, 0, 24'h000133));
`else
        seq.push_back(mk(0, 0, 1, 24'h000123, ST_RUN, 1, 0, 0, 24'h000123));
        seq.push_back(mk(0, 0, 0, 24'h000130, ST_RUN, 1, 0, 0, 24'h000130));
`endif
        foreach (seq[i]) begin
            exp_q.push_back(seq[i].exp);
            tick(seq[i].s, seq[i].c, seq[i].l, seq[i].t);
            got = w_obs; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL lap step%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_pause_clear();
        step_t seq[$];
        seq.push_back(mk(1, 0, 0, 24'h000200, ST_PAUSE, 0, 0, 0, 24'h000200));
        seq.push_back(mk(0, 0, 0, 24'h000201, ST_PAUSE, 0, 0, 0, 24'h000201));
        seq.push_back(mk(0, 1, 0, 24'h000202, ST_IDLE,  0, 1, 0, 24'h000202));
        seq.push_back(mk(0, 1, 0, 24'h000203, ST_IDLE,  0, 0, 0, 24'h000203));
        seq.push_back(mk(0, 0, 0, 24'h000204, ST_IDLE,  0, 0, 0, 24'h000204));
        foreach (seq[i]) begin
            exp_q.push_back(seq[i].exp);
            tick(seq[i].s, seq[i].c, seq[i].l, seq[i].t);
            got = w_obs; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL pause_clear step%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_short_clear();
        step_t seq[$];
        seq.push_back(mk(1, 0, 0, 24'h000300, ST_RUN, 1, 0, 0, 24'h000300));
        seq.push_back(mk(0, 0, 0, 24'h000301, ST_RUN, 1, 0, 0, 24'h000301));
        seq.push_back(mk(0, 1, 0, 24'h000302, ST_RUN, 1, 0, 0, 24'h000302));
        seq.push_back(mk(0, 1, 0, 24'h000303, ST_RUN, 1, 0, 0, 24'h000303));
        seq.push_back(mk(0, 0, 0, 24'h000304, ST_RUN, 1, 0, 0, 24'h000304));
        foreach (seq[i]) begin
            exp_q.push_back(seq[i].exp);
            tick(seq[i].s, seq[i].c, seq[i].l, seq[i].t);
            got = w_obs; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL short_clear step%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_long_clear();
        step_t seq[$];
        logic [23:0] t;
        for (int k = 1; k <= 10; k++) begin
            t = 24'h000400 + 24'(k);
            if (k < 5)       seq.push_back(mk(0, 1, 0, t, ST_RUN,  1, 0, 0, t));
            else if (k == 5) seq.push_back(mk(0, 1, 0, t, ST_IDLE, 0, 1, 0, t));
            else             seq.push_back(mk(0, 1, 0, t, ST_IDLE, 0, 0, 0, t));
        end
        seq.push_back(mk(0, 0, 0, 24'h000420, ST_IDLE, 0, 0, 0, 24'h000420));
        foreach (seq[i]) begin
            exp_q.push_back(seq[i].exp);
            tick(seq[i].s, seq[i].c, seq[i].l, seq[i].t);
            got = w_obs; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL long_clear held%0d got=%h want=%h", i + 1, got, want);
            end
        end
    endtask

    task automatic test_simultaneous();
        step_t seq[$];
        seq.push_back(mk(1, 0, 0, 24'h000500, ST_RUN,   1, 0, 0, 24'h000500));
        seq.push_back(mk(0, 0, 0, 24'h000501, ST_RUN,   1, 0, 0, 24'h000501));
        seq.push_back(mk(1, 0, 0, 24'h000502, ST_PAUSE, 0, 0, 0, 24'h000502));
        seq.push_back(mk(0, 0, 0, 24'h000503, ST_PAUSE, 0, 0, 0, 24'h000503));
        seq.push_back(mk(1, 1, 0, 24'h000504, ST_IDLE,  0, 1, 0, 24'h000504));
        seq.push_back(mk(0, 0, 0, 24'h000505, ST_IDLE,  0, 0, 0, 24'h000505));
        seq.push_back(mk(1, 0, 0, 24'h000506, ST_RUN,   1, 0, 0, 24'h000506));
        seq.push_back(mk(0, 0, 0, 24'h000507, ST_RUN,   1, 0, 0, 24'h000507));
        seq.push_back(mk(1, 0, 1, 24'h000508, ST_PAUSE, 0, 0, 0, 24'h000508));
        seq.push_back(mk(0, 0, 0, 24'h000509, ST_PAUSE, 0, 0, 0, 24'h000509));
        foreach (seq[i]) begin
            exp_q.push_back(seq[i].exp);
            tick(seq[i].s, seq[i].c, seq[i].l, seq[i].t);
            got = w_obs; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL simultaneous step%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        step_t seq[$];
        step_t post[$];
        seq.push_back(mk(1, 0, 0, 24'h000600, ST_RUN, 1, 0, 0, 24'h000600));
        seq.push_back(mk(0, 0, 0, 24'h000601, ST_RUN, 1, 0, 0, 24'h000601));
`ifdef STOPWATCH_LAP_EN
        seq.push_back(mk(0, 0, 1, 24'h000777, ST_LAP, 1, 0, 1, 24'h000777));
        seq.push_back(mk(0, 1, 0, 24'h000778, ST_LAP, 1, 0, 1, 24'h000777));
        seq.push_back(mk(0, 1, 0, 24'h000779, ST_LAP, 1, 0, 1, 24'h000777));
`else
        seq.push_back(mk(0, 1, 0, 24'h000778, ST_RUN, 1, 0, 0, 24'h000778));
        seq.push_back(mk(0, 1, 0, 24'h000779, ST_RUN, 1, 0, 0, 24'h000779));
`endif
        foreach (seq[i]) begin
            exp_q.push_back(seq[i].exp);
            tick(seq[i].s, seq[i].c, seq[i].l, seq[i].t);
            got = w_obs; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_mid_pre step%0d got=%h want=%h", i, got, want);
            end
        end
        // Assert reset between edges with Clear still held and start now pressed.
        key_start = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back('0);
        got = w_obs; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset_async got=%h want=%h", got, want);
        end
        @(negedge clk);
        exp_q.push_back('0);
        got = w_obs; want = exp_q.pop_front(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset_held got=%h want=%h", got, want);
        end
        rst_n = 1'b1;
        post.push_back(mk(1, 0, 0, 24'h000800, ST_IDLE, 0, 0, 0, 24'h000800));
        post.push_back(mk(1, 0, 0, 24'h000801, ST_IDLE, 0, 0, 0, 24'h000801));
        post.push_back(mk(0, 0, 0, 24'h000802, ST_IDLE, 0, 0, 0, 24'h000802));
        post.push_back(mk(1, 0, 0, 24'h000803, ST_RUN,  1, 0, 0, 24'h000803));
        post.push_back(mk(0, 0, 0, 24'h000804, ST_RUN,  1, 0, 0, 24'h000804));
        foreach (post[i]) begin
            exp_q.push_back(post[i].exp);
            tick(post[i].s, post[i].c, post[i].l, post[i].t);
            got = w_obs; want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_release step%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_start();
        test_lap();
        test_pause_clear();
        test_short_clear();
        test_long_clear();
        test_simultaneous();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Mode controller for the stopwatch datapath. Sits between the debounced key outputs (`KeyFilter`) and the `stop_watch` counter / `DigtalTubeDriver` pair, all in the `clk_10MHz` domain.
- Turns filtered key levels into run, stop, clear and lap events, and drives the counter's enable and clear.
- Freezes the value fed to the display while a lap is shown.
- A long press of Clear force-stops and zeroes a running watch.

## Interface
Parameters:
- `CLK_FREQ`, 10000000 — clk frequency in Hz.
- `LONG_PRESS_MS`, 2000 — Clear hold time that forces stop+clear while running.

Ports:
- `clk`  in  1  system clock (10 MHz PLL output).
- `rst_n`  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- `key_start`  in  1  filtered start/stop level; 1 = pressed.
- `key_clear`  in  1  filtered Clear level; 1 = pressed.
- `key_lap`  in  1  filtered lap level; 1 = pressed.
- `time_in`  in  24  live BCD time from counter: {hr_h, hr_l, min_h, min_l, sec_h, sec_l}.
- `cnt_en`  out  1  counter run enable.
- `cnt_clr`  out  1  one-cycle synchronous clear pulse to counter.
- `disp_time`  out  24  BCD time to display driver.
- `disp_frozen`  out  1  1 while lap value is displayed.
- `state_o`  out  2  current state encoding, for LEDs and debug.

## Operation
- Press event: key high this cycle and low the previous cycle, using a registered previous sample per key. Holding a key gives one event only.
- Long-clear event:
  - A hold counter increments each cycle while `key_clear`=1 and the state is RUN or LAP.
  - It fires once when the count reaches LONG_CYC-1, with LONG_CYC = CLK_FREQ/1000*LONG_PRESS_MS.
  - It then saturates until `key_clear` returns to 0.
  - It clears to 0 on release or on any state change.
- States (encoding IDLE=0, RUN=1, PAUSE=2, LAP=3):
  - IDLE: start→RUN. Clear→IDLE with `cnt_clr` pulse. Lap ignored.
  - RUN: start→PAUSE. Lap→LAP. Long-clear→IDLE with `cnt_clr`. Short Clear ignored.
  - LAP: lap→RUN (display goes live). Start→PAUSE (display goes live). Long-clear→IDLE with `cnt_clr`.
  - PAUSE: start→RUN. Clear→IDLE with `cnt_clr`. Lap ignored.
- Simultaneous events in one cycle: priority long-clear > Clear > start > lap. Only the winning event acts; the losers are discarded, not queued.
- `cnt_en` = 1 in RUN and LAP.
- Display register:
  - Loads `time_in` every cycle outside LAP.
  - Holds in LAP, so the held value is `time_in` sampled in the lap-press cycle.
  - `disp_frozen` = 1 in LAP only.
- No arithmetic on `time_in`; it is passed or held bit-exact. Rollover is owned by the counter.
- The hold counter is sized $clog2(LONG_CYC) bits and saturates; it never wraps.

## Timing
- All outputs are registered.
- An event in cycle N updates state, `cnt_en`, `disp_frozen` and `state_o` in cycle N+1.
- `cnt_clr` is high for exactly cycle N+1.
- `disp_time` = `time_in` delayed 1 cycle when live.
- Reset values: state IDLE, `cnt_en` 0, `cnt_clr` 0, `disp_time` 0, `disp_frozen` 0, `state_o` 0, hold counter 0, previous key samples 0.
- A key already high when reset releases produces no event until it is released and pressed again. To achieve this, previous samples load 1 if the key is high in the first post-reset cycle.
- Reset asserted mid-operation: all outputs are forced to reset values immediately (asynchronous); any pending `cnt_clr` is dropped.

## Configuration
- `STOPWATCH_LAP_EN` defined:
  - LAP state, `key_lap` handling and display hold are built.
- Undefined:
  - `key_lap` is unused and LAP is unreachable.
  - `disp_frozen` is tied 0.
  - `disp_time` is still the 1-cycle-registered `time_in`.
  - All other behaviour is identical.

## Structure
- `stopwatch_pkg`: state enum (IDLE/RUN/PAUSE/LAP), `TIME_W`=24, `DIGIT_W`=4.
- Sub-module `key_event`, one per key. It contains:
  - the previous-sample register;
  - a press-pulse output;
  - the optional long-press counter, enabled by an input and parameterized by LONG_CYC.
- The controller FSM and display register live in `stopwatch_ctrl`.

## Test plan
Benches use CLK_FREQ=1000 and LONG_PRESS_MS=5, so LONG_CYC=5.
- Reset, then one start pulse → `cnt_en` 1 one cycle after the press, `state_o`=1.
- RUN, `time_in`=0x000123, lap press → `disp_frozen`=1 and `disp_time` holds 0x000123 while `time_in` advances to 0x000130. A second lap press → live again, `disp_time` follows `time_in` with 1-cycle lag.
- PAUSE, Clear press → `cnt_clr` high exactly 1 cycle, `state_o`=0, `cnt_en` 0. Clear pressed in RUN for 2 cycles → no effect.
- RUN, Clear held 10 cycles → one `cnt_clr` pulse after the 5th held cycle plus 1, state IDLE. No second pulse while the key is still held.
- Start and Clear rising in the same cycle in PAUSE → Clear wins (IDLE, `cnt_clr`), start discarded. Start and lap together in RUN → PAUSE, no lap capture.
- `rst_n` asserted in LAP mid-hold → all outputs 0 immediately. A key held through reset release → no event until re-pressed.
